// File: rtl/he_pkg.sv
// Shared types and default sizes for the histogram-equalization feeder.
//   feed_state_t : feeder FSM states
//   HE_*         : default frame size, result pulse count, pixel width, timeout
package he_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } feed_state_t;

    localparam int unsigned HE_FRAME_PIX = 1024;
    localparam int unsigned HE_OUT_PIX   = 8;
    localparam int unsigned HE_PIX_W     = 8;
    localparam int unsigned HE_TIMEOUT   = 64;

endpackage

// File: rtl/he_frame_ram.sv
// Single-port frame buffer with synchronous read.
//   clk   : clock
//   we    : write enable (writes wdata at addr)
//   re    : read enable; when low the read register loads zero
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data
module he_frame_ram
    import he_pkg::*;
#(
    parameter int unsigned DEPTH = HE_FRAME_PIX,
    parameter int unsigned WIDTH = HE_PIX_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read register doubles as the pixel output register; zero when idle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/he_frame_feeder.sv
// Buffers one frame from a ready/valid source, replays it to the HE stage as a
// gap-free in_valid burst, then waits for the HE result pulses (or a timeout)
// before accepting the next frame.
//   clk, rst             : clock, synchronous active-high reset
//   s_valid/s_data       : source pixel stream; s_ready high while filling
//   in_valid/in_image    : registered pixel burst to the HE stage
//   he_out_valid         : HE stage result pulses
//   busy                 : high while sending or waiting for results
//   frame_done           : one-cycle pulse on normal completion
//   err_timeout          : one-cycle pulse when results do not arrive in time
//   frame_cnt            : completed-frame counter (wraps)
module he_frame_feeder
    import he_pkg::*;
#(
    parameter int unsigned FRAME_PIX = HE_FRAME_PIX,
    parameter int unsigned OUT_PIX   = HE_OUT_PIX,
    parameter int unsigned TIMEOUT   = HE_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic [HE_PIX_W-1:0] s_data,
    output logic                s_ready,
    output logic                in_valid,
    output logic [HE_PIX_W-1:0] in_image,
    input  logic                he_out_valid,
    output logic                busy,
    output logic                frame_done,
    output logic                err_timeout,
    output logic [15:0]         frame_cnt
);

    localparam int unsigned AW = $clog2(FRAME_PIX);
    localparam int unsigned OW = $clog2(OUT_PIX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);
    localparam logic [OW-1:0] LAST_OUT  = OW'(OUT_PIX - 1);
    localparam logic [TW-1:0] LAST_TMO  = TW'(TIMEOUT - 1);

    feed_state_t   state;
    feed_state_t   state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] out_cnt;
    logic [TW-1:0] tmo;

    logic          accept_c;
    logic          last_wr_c;
    logic          last_rd_c;
    logic          done_c;
    logic          tmo_c;
    logic          ram_re_c;
    logic [AW-1:0] ram_addr_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:      if (last_wr_c)        state_nxt = SEND;
            SEND:      if (last_rd_c)        state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_c || tmo_c)  state_nxt = FILL;
            default:                         state_nxt = FILL;
        endcase
    end

    // Output and control decode.
    always_comb begin
        s_ready    = 1'b0;
        busy       = 1'b0;
        accept_c   = 1'b0;
        last_wr_c  = 1'b0;
        last_rd_c  = 1'b0;
        done_c     = 1'b0;
        tmo_c      = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = wr_ptr;
        case (state)
            FILL: begin
                s_ready   = 1'b1;
                accept_c  = s_valid;
                last_wr_c = s_valid && (wr_ptr == LAST_ADDR);
            end
            SEND: begin
                busy       = 1'b1;
                last_rd_c  = (rd_ptr == LAST_ADDR);
                // Gated by rst so the pixel register clears on a reset edge.
                ram_re_c   = !rst;
                ram_addr_c = rd_ptr;
            end
            WAIT_DONE: begin
                busy   = 1'b1;
                done_c = he_out_valid && (out_cnt == LAST_OUT);
                // Completion takes priority over a same-cycle timeout.
                tmo_c  = !done_c && (tmo == LAST_TMO);
            end
            default: ;
        endcase
    end

    // Pointers, result counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_cnt     <= '0;
            tmo         <= '0;
            in_valid    <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            in_valid    <= (state == SEND);
            frame_done  <= done_c;
            err_timeout <= tmo_c;

            if (accept_c) begin
                wr_ptr <= last_wr_c ? '0 : wr_ptr + 1'b1;
            end

            if (last_wr_c) begin
                rd_ptr <= '0;
            end else if (state == SEND) begin
                rd_ptr <= last_rd_c ? '0 : rd_ptr + 1'b1;
            end

            if (state == WAIT_DONE) begin
                if (done_c || tmo_c) begin
                    out_cnt <= '0;
                    tmo     <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                    if (he_out_valid) begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
            end

            if (done_c) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    he_frame_ram #(
        .DEPTH (FRAME_PIX),
        .WIDTH (HE_PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept_c),
        .re    (ram_re_c),
        .addr  (ram_addr_c),
        .wdata (s_data),
        .rdata (in_image)
    );

endmodule

// File: tb/tb_he_frame_feeder.sv
// Randomized bench for he_frame_feeder: frames of known pixels are pushed in,
// the replayed burst is captured and compared, and result-pulse schedules are
// evaluated by a simple count-until-deadline model.
module tb_he_frame_feeder;
    import he_pkg::*;

    localparam int FP = HE_FRAME_PIX;
    localparam int NO = HE_OUT_PIX;
    localparam int TO = HE_TIMEOUT;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        in_valid;
    logic [7:0]  in_image;
    logic        he_out_valid;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_cnt_m = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_q[$];
    int   run_start = -1;
    int   run_len = 0;
    int   runs_done = 0;
    int   zero_viol = 0;
    logic prev_v = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    he_frame_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .in_valid     (in_valid),
        .in_image     (in_image),
        .he_out_valid (he_out_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout),
        .frame_cnt    (frame_cnt)
    );

    // Burst capture: each in_valid run is collected with its start cycle.
    always @(negedge clk) begin
        if (in_valid === 1'b1) begin
            if (prev_v !== 1'b1) begin
                mon_q.delete();
                run_start = cyc;
            end
            mon_q.push_back(in_image);
        end else begin
            if (in_image !== 8'd0) zero_viol++;
            if (prev_v === 1'b1) begin
                run_len = mon_q.size();
                runs_done++;
            end
        end
        prev_v = in_valid;
    end

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int prefix_bad(input int n);
        int bad = 0;
        for (int j = 0; j < n; j++) begin
            if (j >= mon_q.size() || j >= exp_q.size()) bad++;
            else if (mon_q[j] !== exp_q[j]) bad++;
        end
        return bad;
    endfunction

    // gap_mode: 0 none, 1 alternate idle beats, 2 random idle beats.
    // plan: 0 normal, 1 timeout, 2 eighth pulse on last cycle, 3 random.
    task automatic do_frame(input bit rnd_data, input int gap_mode, input int plan,
                            input bit stray, input bit abort);
        int   bad_ready = 0;
        int   runs0;
        int   c0;
        int   w;
        int   cnt = 0;
        int   exp_evt;
        int   done_n = 0;
        int   err_n = 0;
        int   done_at = -1;
        int   err_at = -1;
        int   n;
        bit   exp_done = 1'b0;
        logic busy_w = 1'b0;
        bit   pulse_at[80];
        logic [7:0] pix;

        exp_q.delete();
        runs0 = runs_done;

        for (int i = 0; i < FP; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                s_valid      = 1'b0;
                s_data       = 8'($urandom);
                he_out_valid = stray ? 1'($urandom) : 1'b0;
                tick();
            end
            pix = rnd_data ? 8'($urandom) : 8'(i);
            exp_q.push_back(pix);
            s_valid      = 1'b1;
            s_data       = pix;
            he_out_valid = stray ? 1'($urandom) : 1'b0;
            if (s_ready !== 1'b1) bad_ready++;
            tick();
        end
        s_valid      = 1'b0;
        he_out_valid = 1'b0;
        c0 = cyc;
        w  = c0 + FP;
        check("fill_ready", 64'(bad_ready), 64'd0);
        check("ready_after_fill", 64'(s_ready), 64'd0);
        check("busy_send", 64'(busy), 64'd1);

        foreach (pulse_at[k]) pulse_at[k] = 1'b0;
        case (plan)
            0: for (int k = 2; k < 2 + NO; k++) pulse_at[k] = 1'b1;
            1: for (int k = 3; k < 8; k++) pulse_at[k] = 1'b1;
            2: for (int k = TO - NO; k < TO; k++) pulse_at[k] = 1'b1;
            default: begin
                n = $urandom_range(5, 10);
                for (int j = 0; j < n; j++) pulse_at[$urandom_range(0, 69)] = 1'b1;
            end
        endcase

        // Reference: count pulses until NO is reached or TO cycles elapse.
        exp_evt = w + TO;
        for (int k = 0; k < TO; k++) begin
            if (pulse_at[k]) cnt++;
            if (cnt == NO) begin
                exp_done = 1'b1;
                exp_evt  = w + k + 1;
                break;
            end
        end

        for (int c = c0; c < exp_evt + 4; c++) begin
            s_valid      = 1'b0;
            he_out_valid = 1'b0;
            s_data       = 8'($urandom);
            if (c < w) begin
                if (stray) begin
                    s_valid      = 1'($urandom);
                    he_out_valid = 1'($urandom);
                end
            end else if (c < exp_evt && c - w < TO) begin
                he_out_valid = pulse_at[c - w];
            end
            if (c == w) busy_w = busy;
            if (frame_done === 1'b1) begin done_n++; done_at = c; end
            if (err_timeout === 1'b1) begin err_n++; err_at = c; end

            if (abort && c == c0 + 501) begin
                rst = 1'b1;
                tick();
                rst          = 1'b0;
                s_valid      = 1'b0;
                he_out_valid = 1'b0;
                frame_cnt_m  = 0;
                check("abort_in_valid", 64'(in_valid), 64'd0);
                check("abort_ready", 64'(s_ready), 64'd1);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_frame_cnt", 64'(frame_cnt), 64'd0);
                tick();
                check("abort_run_len", 64'(run_len), 64'd501);
                check("abort_run_start", 64'(run_start), 64'(c0 + 1));
                check("abort_data", 64'(prefix_bad(501)), 64'd0);
                return;
            end
            tick();
        end

        if (exp_done) frame_cnt_m = (frame_cnt_m + 1) % 65536;
        check("burst_runs", 64'(runs_done - runs0), 64'd1);
        check("burst_len", 64'(run_len), 64'(FP));
        check("burst_start", 64'(run_start), 64'(c0 + 1));
        check("burst_data", 64'(prefix_bad(FP)), 64'd0);
        check("busy_wait", 64'(busy_w), 64'd1);
        check("done_pulses", 64'(done_n), exp_done ? 64'd1 : 64'd0);
        check("err_pulses", 64'(err_n), exp_done ? 64'd0 : 64'd1);
        check("event_cycle", exp_done ? 64'(done_at) : 64'(err_at), 64'(exp_evt));
        check("frame_cnt", 64'(frame_cnt), 64'(frame_cnt_m));
        check("ready_back", 64'(s_ready), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        check("idle_image_zero", 64'(zero_viol), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_data       = 8'd0;
        he_out_valid = 1'b0;
        repeat (3) tick();
        check("rst_in_valid", 64'(in_valid), 64'd0);
        check("rst_in_image", 64'(in_image), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err_timeout", 64'(err_timeout), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);

        do_frame(1'b0, 0, 0, 1'b0, 1'b0);   // ramp data, normal completion
        do_frame(1'b1, 1, 1, 1'b1, 1'b0);   // alternating gaps, timeout
        do_frame(1'b1, 2, 2, 1'b1, 1'b0);   // completion on the timeout cycle
        do_frame(1'b1, 0, 0, 1'b1, 1'b1);   // reset in the middle of the burst
        do_frame(1'b0, 2, 0, 1'b0, 1'b0);   // fresh frame after reset
        for (int f = 0; f < 5; f++) begin
            do_frame(1'b1, 2, 3, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
